// File: rtl/led_trail_pwm.sv
// led_trail_pwm
// PWM "comet trail" output stage for the LED scroller. Each channel lights at
// full brightness while its pattern bit is set, then fades out linearly, one
// brightness step per decay prescaler period. With trail_en low the channels
// follow the pattern as plain on/off. All outputs are driven straight from flops.
module led_trail_pwm #(
    parameter int NUM_LEDS  = 7,
    parameter int PWM_BITS  = 4,
    parameter int DECAY_DIV = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                trail_en,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame_start
);

    // Full-scale brightness; the PWM period is MAX cycles, so MAX means always on.
    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;

    // Decay prescaler width; DECAY_DIV = 1 still needs a 1-bit counter.
    localparam int              DEC_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

    logic [PWM_BITS-1:0] level [NUM_LEDS];
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [DEC_W-1:0]    dec_cnt;
    logic                decay_tick;

    // One decay step is due on the last cycle of each prescaler period.
    assign decay_tick = (dec_cnt == DEC_LAST);

    // Free-running PWM phase counter, 0..MAX-1; unaffected by led_in/trail_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Free-running decay prescaler, 0..DECAY_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (dec_cnt == DEC_LAST) begin
            dec_cnt <= '0;
        end else begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // Per-channel brightness: load beats hard-off beats decay; decay stops at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (led_in[i]) begin
                    level[i] <= MAX;
                end else if (!trail_en) begin
                    level[i] <= '0;
                end else if (decay_tick && (level[i] != '0)) begin
                    level[i] <= level[i] - 1'b1;
                end
            end
        end
    end

    // Registered PWM compare and period marker; level changes apply on the next compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                led_out[i] <= (level[i] > pwm_cnt);
            end
            frame_start <= (pwm_cnt == '0);
        end
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// tb_led_trail_pwm
// Bench for led_trail_pwm with PWM_BITS = 4 (MAX = 15) and DECAY_DIV = 4.
// A behavioural model derives the expected outputs from the number of edges
// since reset release (PWM phase and decay ticks by modulo arithmetic) and an
// integer brightness per channel; a compare process checks every cycle.
// Directed scenarios add hand-computed expectations, then random traffic runs.
module tb_led_trail_pwm;

    localparam int NUM_LEDS  = 7;
    localparam int PWM_BITS  = 4;
    localparam int DECAY_DIV = 4;
    localparam int MAX       = (1 << PWM_BITS) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                clk;
    logic                rst_n;
    logic [NUM_LEDS-1:0] led_in;
    logic                trail_en;
    logic [NUM_LEDS-1:0] led_out;
    logic                frame_start;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    led_trail_pwm #(
        .NUM_LEDS  (NUM_LEDS),
        .PWM_BITS  (PWM_BITS),
        .DECAY_DIV (DECAY_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_in      (led_in),
        .trail_en    (trail_en),
        .led_out     (led_out),
        .frame_start (frame_start)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // edge_idx = index of the next non-reset edge since release.
    int                  lvl [NUM_LEDS];
    int                  edge_idx = 0;
    logic [NUM_LEDS-1:0] exp_out = '0;
    logic                exp_fs = 1'b0;
    bit                  model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LEDS; i++) lvl[i] = 0;
            exp_out     = '0;
            exp_fs      = 1'b0;
            edge_idx    = 0;
            model_valid = 1'b1;
        end else begin
            int  phase;
            bit  tick;
            phase = edge_idx % MAX;
            tick  = ((edge_idx % DECAY_DIV) == DECAY_DIV - 1);
            for (int i = 0; i < NUM_LEDS; i++) exp_out[i] = (lvl[i] > phase);
            exp_fs = (phase == 0);
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (led_in[i])          lvl[i] = MAX;
                else if (!trail_en)     lvl[i] = 0;
                else if (tick && lvl[i] > 0) lvl[i] = lvl[i] - 1;
            end
            edge_idx++;
        end
    end

    // ---------------- scoreboard: every-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (led_out !== exp_out) begin
                errors++;
                $display("FAIL model_led_out t=%0t actual=%h expected=%h", $time, led_out, exp_out);
            end
            checks++;
            if (frame_start !== exp_fs) begin
                errors++;
                $display("FAIL model_frame_start t=%0t actual=%b expected=%b", $time, frame_start, exp_fs);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    logic [NUM_LEDS-1:0] exp_q[$];

    // ---------------- stimulus ----------------
    initial begin
        int last_lit;
        bit found;
        rst_n    = 1'b0;
        led_in   = 7'h7F;
        trail_en = 1'b1;

        // Reset held 3 cycles with all inputs high: outputs stay 0.
        repeat (3) begin
            tick();
            check("reset_led_out", 32'(led_out), 32'h0);
            check("reset_frame_start", 32'(frame_start), 32'h0);
        end
        rst_n  = 1'b1;
        led_in = '0;
        tick();
        check("first_frame_start", 32'(frame_start), 32'h1);
        for (int j = 1; j < 45; j++) begin
            tick();
            check("frame_start_period", 32'(frame_start), (j % 15 == 0) ? 32'h1 : 32'h0);
        end

        // Steady on: led_out[0] on every cycle from the 2nd edge.
        led_in = 7'b0000001;
        tick();
        repeat (30) begin
            tick();
            check("steady_on", 32'(led_out), 32'h01);
        end

        // Fade: last high sample was the previous edge.
        led_in   = '0;
        last_lit = 0;
        for (int j = 1; j <= 120; j++) begin
            tick();
            if (led_out[0]) last_lit = j;
            if (j == 1) check("fade_first_full", 32'(led_out[0]), 32'h1);
        end
        check("fade_dark_by_64", 32'(last_lit <= 64), 32'h1);
        check("fade_lit_late", 32'(last_lit >= 30), 32'h1);

        // Load/decay collision: sample led_in[3] on a decay tick edge whose
        // following edge compares against pwm phase 14.
        found = 1'b0;
        for (int j = 0; j < 70 && !found; j++) begin
            if (edge_idx % 60 == 43) found = 1'b1;
            else tick();
        end
        check("collision_align", 32'(found), 32'h1);
        led_in = 7'b0001000;
        tick();
        led_in = '0;
        tick();
        check("collision_full_level", 32'(led_out[3]), 32'h1);
        repeat (20) tick();

        // Hard mode: walking one-hot reproduced 2 cycles later, no trail.
        trail_en = 1'b0;
        repeat (3) tick();
        for (int n = 0; n < 18; n++) begin
            logic [NUM_LEDS-1:0] v;
            v = (n < 14) ? NUM_LEDS'(1 << (n % NUM_LEDS)) : '0;
            if (n >= 2) check("hard_mode", 32'(led_out), 32'(exp_q.pop_front()));
            led_in = v;
            exp_q.push_back(v);
            tick();
        end
        exp_q.delete();

        // Mid-fade reset while channel 2 sits at level 9.
        trail_en = 1'b1;
        led_in   = 7'b0000100;
        tick();
        led_in = '0;
        found  = 1'b0;
        for (int j = 0; j < 80 && !found; j++) begin
            tick();
            if (lvl[2] == 9) found = 1'b1;
        end
        check("midfade_reached_9", 32'(found), 32'h1);
        rst_n = 1'b0;
        tick();
        check("midfade_reset_led_out", 32'(led_out), 32'h0);
        check("midfade_reset_frame_start", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        tick();
        check("midfade_restart_frame", 32'(frame_start), 32'h1);
        repeat (60) begin
            check("midfade_stays_dark", 32'(led_out), 32'h0);
            tick();
        end

        // Random traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       led_in = NUM_LEDS'(1 << $urandom_range(0, NUM_LEDS - 1));
                1:       led_in = NUM_LEDS'($urandom_range(0, 127));
                default: led_in = '0;
            endcase
            if ($urandom_range(0, 49) == 0) trail_en = ~trail_en;
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n  = 1'b1;
        led_in = '0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
